// File: rtl/useq_seq_if.sv
// Control-word / decoder side of the microprogram sequencer.
interface useq_seq_if #(
  parameter int unsigned UADDR_W = 6,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned NFLAGS  = 4,
  parameter int unsigned CNT_W   = 4
);
  localparam int unsigned CSEL_W  = $clog2(NFLAGS);
  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

  logic                stall;
  logic [2:0]          mode;
  logic [UADDR_W-1:0]  target;
  logic [UADDR_W-1:0]  dispatch;
  logic [NFLAGS-1:0]   flags;
  logic [CSEL_W-1:0]   csel;
  logic                cpol;
  logic                ld_cnt;
  logic [CNT_W-1:0]    cnt_val;
  logic [UADDR_W-1:0]  uaddr;
  logic [DEPTH_W-1:0]  depth;
  logic                cnt_zero;
  logic                ovf;
  logic                unf;

  modport master (
    output stall, mode, target, dispatch, flags, csel, cpol, ld_cnt, cnt_val,
    input  uaddr, depth, cnt_zero, ovf, unf
  );

  modport slave (
    input  stall, mode, target, dispatch, flags, csel, cpol, ld_cnt, cnt_val,
    output uaddr, depth, cnt_zero, ovf, unf
  );
endinterface

// File: rtl/useq_seq.sv
// Microprogram sequencer: selects the next control-store address each cycle
// (increment, jump, dispatch, conditional, call/return, counted loop, fetch).
module useq_seq #(
  parameter int unsigned        UADDR_W    = 6,
  parameter int unsigned        DEPTH      = 4,
  parameter int unsigned        NFLAGS     = 4,
  parameter int unsigned        CNT_W      = 4,
  parameter logic [UADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [UADDR_W-1:0] FAULT_ADDR = '1
) (
  input  logic          clk,
  input  logic          reset,
  useq_seq_if.slave     bus
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

  localparam logic [2:0] M_NEXT  = 3'd0;
  localparam logic [2:0] M_JUMP  = 3'd1;
  localparam logic [2:0] M_DISP  = 3'd2;
  localparam logic [2:0] M_COND  = 3'd3;
  localparam logic [2:0] M_CALL  = 3'd4;
  localparam logic [2:0] M_RET   = 3'd5;
  localparam logic [2:0] M_LOOP  = 3'd6;
  localparam logic [2:0] M_FETCH = 3'd7;

  logic [UADDR_W-1:0] uaddr_q, uaddr_n, inc;
  logic [DEPTH_W-1:0] depth_q, depth_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               ovf_q, ovf_n, unf_q, unf_n;
  logic               push;
  logic               flag_hit;

  // Entry DEPTH is never written; it only keeps the index width equal to depth.
  logic [UADDR_W-1:0] stack [DEPTH+1];

  assign inc = uaddr_q + UADDR_W'(1);

  // Out-of-range flag selects read as not-taken.
  assign flag_hit = (32'(bus.csel) < NFLAGS) && (bus.flags[bus.csel] == bus.cpol);

  // Next-address, stack, counter and error-flag selection.
  always_comb begin
    uaddr_n = uaddr_q;
    depth_n = depth_q;
    cnt_n   = cnt_q;
    ovf_n   = ovf_q;
    unf_n   = unf_q;
    push    = 1'b0;
    if (!bus.stall) begin
      case (bus.mode)
        M_NEXT:  uaddr_n = inc;
        M_JUMP:  uaddr_n = bus.target;
        M_DISP:  uaddr_n = bus.dispatch;
        M_COND:  uaddr_n = flag_hit ? bus.target : inc;
        M_CALL: begin
          if (32'(depth_q) < DEPTH) begin
            push    = 1'b1;
            depth_n = depth_q + DEPTH_W'(1);
            uaddr_n = bus.target;
          end else begin
            ovf_n   = 1'b1;
            uaddr_n = FAULT_ADDR;
          end
        end
        M_RET: begin
          if (depth_q != '0) begin
            depth_n = depth_q - DEPTH_W'(1);
            uaddr_n = stack[depth_q - DEPTH_W'(1)];
          end else begin
            unf_n   = 1'b1;
            uaddr_n = FAULT_ADDR;
          end
        end
        M_LOOP: begin
          if (cnt_q != '0) begin
            cnt_n   = cnt_q - CNT_W'(1);
            uaddr_n = bus.target;
          end else begin
            uaddr_n = inc;
          end
        end
        M_FETCH: uaddr_n = RESET_ADDR;
        default: uaddr_n = inc;
      endcase
      // Load wins over the loop decrement; the loop decision above used the old count.
      if (bus.ld_cnt) cnt_n = bus.cnt_val;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uaddr_q <= RESET_ADDR;
      depth_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      uaddr_q <= uaddr_n;
      depth_q <= depth_n;
      cnt_q   <= cnt_n;
      ovf_q   <= ovf_n;
      unf_q   <= unf_n;
    end
  end

  // Return-stack storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) stack[depth_q] <= inc;
  end

  assign bus.uaddr    = uaddr_q;
  assign bus.depth    = depth_q;
  assign bus.cnt_zero = (cnt_q == '0);
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;

endmodule

// File: tb/tb_useq_seq.sv
// Directed, table-driven bench for the microprogram sequencer.
module tb_useq_seq;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, DISP = 3'd2, COND = 3'd3,
                         CALL = 3'd4, RET  = 3'd5, LOOP = 3'd6, FETCH = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  useq_seq_if #(.UADDR_W(6), .DEPTH(4), .NFLAGS(4), .CNT_W(4)) bus ();

  useq_seq #(.UADDR_W(6), .DEPTH(4), .NFLAGS(4), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic [5:0] target;
    logic [5:0] disp;
    logic [3:0] flags;
    logic [1:0] csel;
    logic       cpol;
    logic       ld;
    logic [3:0] cval;
    int         eu;
    int         ed;
    int         ecz;
    int         eovf;
    int         eunf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] m, int t, int d, int f, int cs, int cp,
                              int ld, int cv, int eu, int ed, int ecz, int eo, int eun);
    vec_t v;
    v.mode = m; v.target = 6'(t); v.disp = 6'(d); v.flags = 4'(f);
    v.csel = 2'(cs); v.cpol = 1'(cp); v.ld = 1'(ld); v.cval = 4'(cv);
    v.eu = eu; v.ed = ed; v.ecz = ecz; v.eovf = eo; v.eunf = eun;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eu, input int ed, input int ecz,
                         input int eo, input int eun);
    chk({tag, ".uaddr"}, int'(bus.uaddr), eu);
    chk({tag, ".depth"}, int'(bus.depth), ed);
    chk({tag, ".cnt_zero"}, int'(bus.cnt_zero), ecz);
    chk({tag, ".ovf"}, int'(bus.ovf), eo);
    chk({tag, ".unf"}, int'(bus.unf), eun);
  endtask

  task automatic drive(input logic [2:0] m, input int t, input int ld, input int cv);
    bus.stall   = 1'b0;
    bus.mode    = m;
    bus.target  = 6'(t);
    bus.dispatch = '0;
    bus.flags   = '0;
    bus.csel    = '0;
    bus.cpol    = 1'b0;
    bus.ld_cnt  = 1'(ld);
    bus.cnt_val = 4'(cv);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(NEXT, 0, 0, 0);

    //      mode  tgt disp flg cs cp ld cv   eu ed cz ov un
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0));
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0));
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0));
    vecs.push_back(mk(JUMP,  5,  0, 0, 0, 0, 0, 0,   5, 0, 1, 0, 0));
    vecs.push_back(mk(CALL, 10,  0, 0, 0, 0, 0, 0,  10, 1, 1, 0, 0));
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 0, 0,  11, 1, 1, 0, 0));
    vecs.push_back(mk(RET,   0,  0, 0, 0, 0, 0, 0,   6, 0, 1, 0, 0));
    vecs.push_back(mk(COND, 40,  0, 4, 2, 1, 0, 0,  40, 0, 1, 0, 0));
    vecs.push_back(mk(COND, 40,  0, 4, 2, 0, 0, 0,  41, 0, 1, 0, 0));
    vecs.push_back(mk(DISP,  0, 33, 0, 0, 0, 0, 0,  33, 0, 1, 0, 0));
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 1, 3,  34, 0, 0, 0, 0));
    vecs.push_back(mk(JUMP, 21,  0, 0, 0, 0, 0, 0,  21, 0, 0, 0, 0));
    vecs.push_back(mk(LOOP, 20,  0, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0));
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 0, 0,  21, 0, 0, 0, 0));
    vecs.push_back(mk(LOOP, 20,  0, 0, 0, 0, 0, 0,  20, 0, 0, 0, 0));
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 0, 0,  21, 0, 0, 0, 0));
    vecs.push_back(mk(LOOP, 20,  0, 0, 0, 0, 0, 0,  20, 0, 1, 0, 0));
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 0, 0,  21, 0, 1, 0, 0));
    vecs.push_back(mk(LOOP, 20,  0, 0, 0, 0, 0, 0,  22, 0, 1, 0, 0));
    vecs.push_back(mk(CALL, 50,  0, 0, 0, 0, 0, 0,  50, 1, 1, 0, 0));
    vecs.push_back(mk(CALL, 51,  0, 0, 0, 0, 0, 0,  51, 2, 1, 0, 0));
    vecs.push_back(mk(CALL, 52,  0, 0, 0, 0, 0, 0,  52, 3, 1, 0, 0));
    vecs.push_back(mk(CALL, 53,  0, 0, 0, 0, 0, 0,  53, 4, 1, 0, 0));
    vecs.push_back(mk(CALL, 54,  0, 0, 0, 0, 0, 0,  63, 4, 1, 1, 0));
    vecs.push_back(mk(RET,   0,  0, 0, 0, 0, 0, 0,  53, 3, 1, 1, 0));
    vecs.push_back(mk(RET,   0,  0, 0, 0, 0, 0, 0,  52, 2, 1, 1, 0));
    vecs.push_back(mk(RET,   0,  0, 0, 0, 0, 0, 0,  51, 1, 1, 1, 0));
    vecs.push_back(mk(RET,   0,  0, 0, 0, 0, 0, 0,  23, 0, 1, 1, 0));
    vecs.push_back(mk(RET,   0,  0, 0, 0, 0, 0, 0,  63, 0, 1, 1, 1));
    vecs.push_back(mk(NEXT,  0,  0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1));
    vecs.push_back(mk(JUMP, 63,  0, 0, 0, 0, 0, 0,  63, 0, 1, 1, 1));
    vecs.push_back(mk(CALL,  7,  0, 0, 0, 0, 0, 0,   7, 1, 1, 1, 1));
    vecs.push_back(mk(RET,   0,  0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1));
    vecs.push_back(mk(FETCH, 9,  0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1));

    // Reset state before any edge.
    #2;
    chk_all("reset", 0, 0, 1, 0, 0);
    tick();
    reset = 1'b0;

    foreach (vecs[i]) begin
      bus.stall    = 1'b0;
      bus.mode     = vecs[i].mode;
      bus.target   = vecs[i].target;
      bus.dispatch = vecs[i].disp;
      bus.flags    = vecs[i].flags;
      bus.csel     = vecs[i].csel;
      bus.cpol     = vecs[i].cpol;
      bus.ld_cnt   = vecs[i].ld;
      bus.cnt_val  = vecs[i].cval;
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].eu, vecs[i].ed, vecs[i].ecz,
              vecs[i].eovf, vecs[i].eunf);
    end

    // Sticky error flags survive further cycles.
    drive(NEXT, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_all($sformatf("sticky%0d", k), k, 0, 1, 1, 1);
    end

    // Mid-cycle asynchronous reset, then normal first edge.
    drive(CALL, 9, 0, 0);
    tick();
    chk_all("pre_arst", 9, 1, 1, 1, 1);
    drive(NEXT, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk_all("arst", 0, 0, 1, 0, 0);
    reset = 1'b0;
    tick();
    chk_all("post_arst", 1, 0, 1, 0, 0);

    // Stall freezes everything, including a pending CALL and counter load.
    drive(NEXT, 0, 1, 2);
    tick();
    chk_all("ld2", 2, 0, 0, 0, 0);
    drive(CALL, 30, 1, 0);
    bus.stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all($sformatf("stall%0d", k), 2, 0, 0, 0, 0);
    end
    drive(CALL, 30, 0, 0);
    tick();
    chk_all("unstall_call", 30, 1, 0, 0, 0);
    drive(NEXT, 0, 0, 0);
    tick();
    chk_all("after_call", 31, 1, 0, 0, 0);

    // LOOP with a simultaneous load: taken on old count, counter becomes 5.
    drive(LOOP, 40, 1, 5);
    tick();
    chk_all("loop_ld", 40, 1, 0, 0, 0);
    drive(LOOP, 40, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all($sformatf("loop5_%0d", k), 40, 1, (k == 5) ? 1 : 0, 0, 0);
    end
    tick();
    chk_all("loop_exit", 41, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
